fir_sched_ctrl: RTL

FIR_SCHED_CTRL -- requirements
Module: fir_sched_ctrl

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 41 ++++
 rtl/fir_sched_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR scheduling controller and its coefficient bank.
package fir_pkg;

  localparam int N_DEF      = 9;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;

  typedef enum logic [1:0] {
    INIT_FLUSH,
    RUN,
    FLUSH,
    SWAP
  } fir_state_e;

  // Largest positive coefficient of width w, i.e. gain ~1.0 in Q(w-1).
  function automatic logic [63:0] unity_coef(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam logic [COEF_W_DEF-1:0] COEF_UNITY = COEF_W_DEF'(unity_coef(COEF_W_DEF));

endpackage

// File: rtl/fir_coef_bank.sv
// Active/shadow coefficient register pair: writes land in shadow, swap copies shadow to active.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(N)-1:0]     wr_addr,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     swap,
  output logic signed [COEF_W-1:0] active [0:N-1]
);

  localparam logic signed [COEF_W-1:0] UNITY =
    (COEF_W == COEF_W_DEF) ? COEF_W'(COEF_UNITY) : COEF_W'(unity_coef(COEF_W));

  logic signed [COEF_W-1:0] shadow [0:N-1];

  // Reset wins over a same-cycle swap so an interrupted commit is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < N; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

endmodule

// File: rtl/fir_sched_ctrl.sv
// Scheduler for a transposed FIR: feeds samples, flushes partial sums, and swaps
// coefficient banks without mixing old and new taps in any output.
module fir_sched_ctrl
  import fir_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic signed [DATA_W-1:0] fir_x,
  output logic signed [COEF_W-1:0] fir_h [0:N-1],
  input  logic signed [DATA_W-1:0] fir_y,
  output logic                     m_valid,
  output logic signed [DATA_W-1:0] m_data,
  input  logic                     cw_en,
  input  logic [$clog2(N)-1:0]     cw_addr,
  input  logic signed [COEF_W-1:0] cw_data,
  input  logic                     commit,
  output logic                     busy,
  output logic                     cw_err,
  output fir_state_e               state_dbg
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] FLUSH_LAST = AW'(N - 2);

  fir_state_e    state;
  fir_state_e    state_next;
  logic [AW-1:0] flush_cnt;
  logic          flush_last;
  logic          accept;
  logic          wr_en;
  logic          swap;

  // Handshake: a sample transfers on any rising edge where s_valid && s_ready;
  // s_ready depends only on state. m_valid has no ready and is never stalled.
  assign accept     = s_valid && s_ready;
  assign fir_x      = accept ? s_data : '0;
  assign flush_last = (flush_cnt == FLUSH_LAST);
  assign wr_en      = cw_en && !busy && (32'(cw_addr) < N);
  assign m_data     = fir_y;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b1;
    swap       = 1'b0;
    case (state)
      INIT_FLUSH: if (flush_last) state_next = RUN;
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (commit) state_next = FLUSH;
      end
      FLUSH: if (flush_last) state_next = SWAP;
      SWAP: begin
        swap       = 1'b1;
        state_next = RUN;
      end
      default: state_next = INIT_FLUSH;
    endcase
  end

  // The FIR advances every clock, so zero input for N-1 cycles empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_FLUSH;
      flush_cnt <= '0;
      m_valid   <= 1'b0;
      cw_err    <= 1'b0;
    end else begin
      state     <= state_next;
      m_valid   <= accept;
      cw_err    <= cw_en && !wr_en;
      if ((state == INIT_FLUSH || state == FLUSH) && !flush_last) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  fir_coef_bank #(
    .N      (N),
    .COEF_W (COEF_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (cw_addr),
    .wr_data (cw_data),
    .swap    (swap),
    .active  (fir_h)
  );

endmodule
